// File: rtl/zero_in_channel.sv
// ----------------------------------------------------------------------------
// zero_in_channel
//
// Input-channel responder for the zero machine. A host fills a circular buffer
// of NIn words while the channel is in LOAD. It then seals the channel, and
// the machine reads the words back in load order with single-cycle `in`
// requests. Once every loaded word has been popped, the channel sits in DONE.
// In DONE, every further request is answered as an underflow.
//
// Ports
//   clock         system clock; all state updates on the rising edge
//   reset         asynchronous, active-high reset
//   load_valid    host offers load_data this cycle
//   load_data     word to append to the channel
//   load_ready    channel can accept a word this cycle (combinational)
//   seal          host closes loading; the channel moves to SERVE, or to DONE
//                 if it is empty
//   in_req        machine `in` instruction: pop one word (one pulse per pop)
//   in_valid      one-cycle response pulse, one cycle after in_req
//   in_data       last popped word; holds its value between pops
//   in_underflow  qualifies in_valid: the pop found the channel empty
//   in_size       words still unread (the inSize value), registered
//   state         0 = LOAD, 1 = SERVE, 2 = DONE
//   drained       high while in DONE
// ----------------------------------------------------------------------------
module zero_in_channel #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn                = 3,
    parameter int CountWidth         = 12
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load_valid,
    input  logic [MemoryElementWidth-1:0] load_data,
    output logic                          load_ready,
    input  logic                          seal,
    input  logic                          in_req,
    output logic                          in_valid,
    output logic [MemoryElementWidth-1:0] in_data,
    output logic                          in_underflow,
    output logic [CountWidth-1:0]         in_size,
    output logic [1:0]                    state,
    output logic                          drained
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int PtrWidth = (NIn > 1) ? $clog2(NIn) : 1;

    state_e                        state_q, state_d;
    logic [PtrWidth-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0]         count_q, count_d;
    logic                          in_valid_q, in_valid_d;
    logic                          in_underflow_q, in_underflow_d;
    logic [MemoryElementWidth-1:0] in_data_q, in_data_d;

    // Storage is deliberately left out of reset: the contents survive a reset,
    // and only the pointers and the count are cleared.
    logic [MemoryElementWidth-1:0] mem [NIn];

    logic accept;
    logic pop;

    // Pointer increment with a wrap at NIn-1, so NIn does not have to be a
    // power of two.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(NIn - 1)) ? '0 : p + 1'b1;
    endfunction

    assign load_ready = (state_q == ST_LOAD) && (count_q < CountWidth'(NIn));
    assign accept     = load_valid && load_ready;
    // SERVE is entered only with count > 0 and is left when count reaches 0.
    // The count guard here is a safety net.
    assign pop        = (state_q == ST_SERVE) && in_req && (count_q != '0);

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        in_data_d      = in_data_q;
        in_valid_d     = 1'b0;
        in_underflow_d = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                    count_d  = count_q + 1'b1;
                end
                // The seal decision uses the count after this edge's load, so
                // a word offered on the same edge as seal is kept.
                if (seal)
                    state_d = (count_d == '0) ? ST_DONE : ST_SERVE;
            end
            ST_SERVE: begin
                if (pop) begin
                    in_valid_d = 1'b1;
                    in_data_d  = mem[rd_ptr_q];
                    rd_ptr_d   = ptr_inc(rd_ptr_q);
                    count_d    = count_q - 1'b1;
                    if (count_d == '0)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // An empty channel answers with underflow and leaves in_data
                // untouched, so the machine's `in` acts as a no-op.
                if (in_req) begin
                    in_valid_d     = 1'b1;
                    in_underflow_d = 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_LOAD;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            in_valid_q     <= 1'b0;
            in_underflow_q <= 1'b0;
            in_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            in_valid_q     <= in_valid_d;
            in_underflow_q <= in_underflow_d;
            in_data_q      <= in_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept)
            mem[wr_ptr_q] <= load_data;
    end

    assign in_valid     = in_valid_q;
    assign in_underflow = in_underflow_q;
    assign in_data      = in_data_q;
    assign in_size      = count_q;
    assign state        = state_q;
    assign drained      = (state_q == ST_DONE);

endmodule

// File: tb/tb_zero_in_channel.sv
module tb_zero_in_channel;

    localparam int W  = 12;
    localparam int N  = 3;
    localparam int CW = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic          seal = 1'b0;
    logic          in_req = 1'b0;
    logic          load_ready;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_underflow;
    logic [CW-1:0] in_size;
    logic [1:0]    state;
    logic          drained;

    zero_in_channel #(
        .MemoryElementWidth(W),
        .NIn(N),
        .CountWidth(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_ready(load_ready),
        .seal(seal),
        .in_req(in_req),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_underflow(in_underflow),
        .in_size(in_size),
        .state(state),
        .drained(drained)
    );

    always #5 clock = ~clock;

    // Reference model: the channel contents are a FIFO queue, and the phase
    // is 0 = LOAD, 1 = SERVE, 2 = DONE.
    int q[$];
    int mst;
    int last_data;
    bit exp_v;
    bit exp_uf;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic check_all(input string ph);
        check({ph, ".load_ready"},   32'(load_ready),   32'(mst == 0 && q.size() < N));
        check({ph, ".in_valid"},     32'(in_valid),     32'(exp_v));
        check({ph, ".in_underflow"}, 32'(in_underflow), 32'(exp_uf));
        check({ph, ".in_data"},      32'(in_data),      32'(last_data));
        check({ph, ".in_size"},      32'(in_size),      32'(q.size()));
        check({ph, ".state"},        32'(state),        32'(mst));
        check({ph, ".drained"},      32'(drained),      32'(mst == 2));
    endtask

    task automatic model_reset();
        q.delete();
        mst       = 0;
        last_data = 0;
        exp_v     = 0;
        exp_uf    = 0;
    endtask

    // Drive one cycle of inputs, let the edge occur, advance the model, and
    // check the DUT outputs 1 time unit after the edge.
    task automatic cycle(input bit lv, input int ld, input bit sl, input bit rq, input string ph);
        logic [31:0] ldv;
        ldv        = 32'(ld);
        load_valid = lv;
        load_data  = ldv[W-1:0];
        seal       = sl;
        in_req     = rq;
        @(posedge clock);
        exp_v  = 0;
        exp_uf = 0;
        case (mst)
            0: begin
                if (lv && q.size() < N) q.push_back(ld);
                if (sl) mst = (q.size() == 0) ? 2 : 1;
            end
            1: if (rq) begin
                exp_v     = 1;
                last_data = q.pop_front();
                if (q.size() == 0) mst = 2;
            end
            default: if (rq) begin
                exp_v  = 1;
                exp_uf = 1;
            end
        endcase
        #1;
        load_valid = 0;
        seal       = 0;
        in_req     = 0;
        check_all(ph);
    endtask

    task automatic do_reset(input string ph);
        reset = 1;
        #1;
        model_reset();
        check_all(ph);
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("por");
        @(posedge clock);
        #1;
        reset = 0;

        // Basic load, offer to a full buffer, seal, drain, then underflow.
        cycle(1, 33, 0, 0, "ld33");
        cycle(1, 22, 0, 1, "ld22_req_ignored");
        cycle(1, 11, 0, 0, "ld11");
        check("full.load_ready", 32'(load_ready), 32'd0);
        cycle(1, 44, 0, 0, "ld44_dropped");
        cycle(0, 0, 1, 0, "seal");
        check("seal.in_size", 32'(in_size), 32'd3);
        cycle(1, 99, 0, 1, "pop1");
        check("pop1.data", 32'(in_data), 32'd33);
        cycle(0, 0, 0, 1, "pop2");
        check("pop2.data", 32'(in_data), 32'd22);
        cycle(0, 0, 0, 1, "pop3");
        check("pop3.data", 32'(in_data), 32'd11);
        check("pop3.drained", 32'(drained), 32'd1);
        cycle(0, 0, 1, 1, "underflow");
        check("underflow.flag", 32'(in_underflow), 32'd1);
        check("underflow.data", 32'(in_data), 32'd11);
        cycle(0, 0, 0, 0, "idle_done");

        // Load and seal on the same edge.
        do_reset("rst2");
        cycle(1, 7, 0, 0, "ld7");
        cycle(1, 8, 0, 0, "ld8");
        cycle(1, 5, 1, 0, "ld5_seal");
        check("simul.in_size", 32'(in_size), 32'd3);
        cycle(0, 0, 0, 1, "p7");
        check("p7.data", 32'(in_data), 32'd7);
        cycle(0, 0, 0, 1, "p8");
        check("p8.data", 32'(in_data), 32'd8);
        cycle(0, 0, 0, 1, "p5");
        check("p5.data", 32'(in_data), 32'd5);

        // Seal with no loads goes straight to DONE.
        do_reset("rst3");
        cycle(0, 0, 1, 0, "empty_seal");
        check("empty_seal.state", 32'(state), 32'd2);
        cycle(0, 0, 0, 1, "empty_req");

        // Asynchronous reset in the middle of SERVE.
        do_reset("rst4");
        cycle(1, 100, 0, 0, "a1");
        cycle(1, 200, 0, 0, "a2");
        cycle(1, 300, 1, 0, "a3_seal");
        cycle(0, 0, 0, 1, "apop");
        check("apop.in_size", 32'(in_size), 32'd2);
        #2;
        reset = 1;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        reset = 0;
        cycle(1, 1, 0, 0, "r1");
        cycle(1, 2, 1, 0, "r2_seal");
        cycle(0, 0, 0, 1, "rp1");
        check("rp1.data", 32'(in_data), 32'd1);
        cycle(0, 0, 0, 1, "rp2");
        check("rp2.data", 32'(in_data), 32'd2);

        // Randomized episodes compared against the queue model.
        for (int e = 0; e < 25; e++) begin
            do_reset("rnd_rst");
            for (int c = 0; c < 30; c++) begin
                cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                      ($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)), "rnd");
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/zero_in_channel.md
Name: zero_in_channel

Overview:
- Input-channel responder for the zero machine. A host loads a sequence of words; the machine side then reads them one at a time.
- Serves the two input instructions:
  - inSize: returns the number of words still unread.
  - in: pops the next word, or does nothing when the channel is empty.
- Storage is a circular buffer of NIn words. A small state machine sequences LOAD, SERVE and DONE, and reports underflow.

Parameters:
MemoryElementWidth, 12, width of each channel word
NIn, 3, channel capacity in words (>=1)
CountWidth, 12, width of in_size and position counters; must hold NIn

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous active-high reset
load_valid  input  1  host offers load_data
load_data  input  MemoryElementWidth  word to append
load_ready  output  1  buffer accepts a word this cycle
seal  input  1  host closes loading; channel starts serving
in_req  input  1  machine in instruction: pop one word (single-cycle pulse)
in_valid  output  1  one-cycle pulse: response to in_req
in_data  output  MemoryElementWidth  popped word; holds its value between pops
in_underflow  output  1  qualifies in_valid: pop found channel empty
in_size  output  CountWidth  words remaining (inSize value), registered
state  output  2  0=LOAD, 1=SERVE, 2=DONE
drained  output  1  high in DONE

Behaviour:
- Reset (async, any time, including mid-load or mid-serve):
  - state=LOAD, write pointer = read pointer = count = 0.
  - load_ready=1, in_valid=0, in_underflow=0, in_data=0, in_size=0, drained=0.
  - Buffer contents are not cleared.
- LOAD state:
  - load_ready = (count < NIn), combinational from count.
  - A word is accepted on a posedge with load_valid && load_ready:
    - it is written at the write pointer;
    - the write pointer advances, wrapping NIn-1 -> 0;
    - count and in_size increment.
  - load_valid while full: word dropped, no state change.
  - in_req in LOAD: ignored, no in_valid.
  - seal high on a posedge:
    - next state is SERVE, or DONE if count is 0 after that edge's load is applied;
    - load_ready goes to 0 from the next cycle;
    - if load_valid and seal are both high in the same cycle, the word is accepted first, then the channel seals.
- SERVE state:
  - load_ready=0; load_valid is ignored.
  - in_req with count>0, response one cycle later:
    - in_valid=1, in_underflow=0;
    - in_data = word at the read pointer;
    - the read pointer advances with wrap;
    - count and in_size decrement.
    - Latency: in_valid exactly one cycle after the in_req edge, high for exactly one cycle.
  - When count reaches 0 after a pop, next state is DONE.
  - in_req held high for multiple cycles: one pop per cycle.
- DONE state:
  - in_req produces in_valid=1 and in_underflow=1.
  - in_data, pointers, count and in_size are unchanged; the machine's in behaves as a no-op.
  - drained=1.
  - DONE is left only by reset.
- seal is ignored outside LOAD.
- Wrap-around: NIn loads followed by NIn pops must return the words in load order, whatever the starting pointer positions.
- in_size always equals loaded minus popped, never negative, never above NIn.

Test Plan:
- Reset, load 33,22,11, seal:
  - in_size=3, state=SERVE.
  - Three in_req pulses give in_data 33,22,11.
  - in_size goes 2,1,0, then state=DONE and drained=1.
- Full: with NIn=3, offer a 4th word 44 while in LOAD:
  - load_ready=0 and the word is dropped.
  - After seal, pops return 33,22,11 only.
- Underflow: in DONE, an in_req gives in_valid=1, in_underflow=1, in_data still 11, in_size=0.
- Simultaneous edge: load_valid=1 with data 5 and seal=1 on the same edge, after two words 7,8:
  - in_size=3.
  - Pops return 7,8,5.
- Empty seal: seal with no loads leads directly to DONE.
  - The first in_req then gives in_underflow=1 and in_size=0.
- Reset mid-serve: after one pop (in_size=2), assert reset asynchronously:
  - all outputs return to their reset values immediately, without waiting for a clock edge.
  - Reload 1,2 and seal: pops give 1,2.
